// File: rtl/dm_bank.sv
// rtl/dm_bank.sv - MEM-stage data memory with sub-word access, address checks and reset clear sweep
module dm_bank #(
  parameter int          ADDR_WIDTH     = 12,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        we,
  input  logic        re,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        exc_adel,
  output logic        exc_ades
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, cnt_next;
  logic [31:0]           mem [DEPTH];

  logic [31:0]           off;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  bad;
  logic                  is_byte, is_half, is_signed;
  logic [31:0]           cur_word;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [31:0]           lane_data;
  logic [31:0]           wmask, wlane, merged;
  logic                  store_ok;

  // Wrapping subtraction makes addresses below the base land far out of range.
  assign off = addr - BASE_ADDR;
  assign idx = off[ADDR_WIDTH+1:2];

  // When the memory spans the whole 32-bit space nothing can be out of range.
  if (ADDR_WIDTH + 2 >= 32) begin : g_full_range
    assign out_of_range = 1'b0;
  end else begin : g_part_range
    assign out_of_range = |off[31:ADDR_WIDTH+2];
  end

  // Access decode, address checks, load extraction and store lane merge.
  always_comb begin
    is_half    = (op == 3'd1) || (op == 3'd2);
    is_byte    = (op == 3'd3) || (op == 3'd4);
    is_signed  = (op == 3'd2) || (op == 3'd4);
    misaligned = (is_half & addr[0]) | (~is_half & ~is_byte & (addr[1:0] != 2'b00));
    bad        = misaligned | out_of_range;
    busy       = (state == CLEAR);
    exc_ades   = we & bad & ~busy;
    exc_adel   = re & ~we & bad & ~busy;
    store_ok   = we & ~bad & ~busy;

    cur_word = mem[idx];
    sel_byte = cur_word[{addr[1:0], 3'b000} +: 8];
    sel_half = addr[1] ? cur_word[31:16] : cur_word[15:0];

    if (is_byte) begin
      lane_data = {{24{is_signed & sel_byte[7]}}, sel_byte};
      wmask     = 32'h0000_00FF << {addr[1:0], 3'b000};
      wlane     = {4{wdata[7:0]}};
    end else if (is_half) begin
      lane_data = {{16{is_signed & sel_half[15]}}, sel_half};
      wmask     = addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      wlane     = {2{wdata[15:0]}};
    end else begin
      lane_data = cur_word;
      wmask     = 32'hFFFF_FFFF;
      wlane     = wdata;
    end

    merged = (cur_word & ~wmask) | (wlane & wmask);
    rdata  = (re & ~bad & ~busy) ? lane_data : 32'h0;
  end

  // Clear/ready state and sweep counter; reset always restarts from word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? CLEAR : READY;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Sweep advances one word per edge and leaves CLEAR after the last word.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (state == CLEAR) begin
      cnt_next = cnt + 1'b1;
      if (cnt == LAST_IDX) begin
        state_next = READY;
      end
    end
  end

  // Single write port: the sweep owns it while busy, stores own it once ready.
  always_ff @(posedge clk) begin
    if (!reset && state == CLEAR) begin
      mem[cnt] <= 32'h0;
    end else if (store_ok) begin
      mem[idx] <= merged;
`ifndef SYNTHESIS
      $display("%d@%08h: *%08h <= %08h", $time, pc, addr & 32'hFFFF_FFFC, merged);
`endif
    end
  end

endmodule

// File: tb/tb_dm_bank.sv
// tb/tb_dm_bank.sv - self-checking bench for dm_bank
module tb_dm_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;

  logic        a_we, a_re;
  logic [2:0]  a_op;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_busy, a_adel, a_ades;

  logic        b_we, b_re;
  logic [2:0]  b_op;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_busy, b_adel, b_ades;

  int tests = 0;
  int fails = 0;

  // byte-addressed reference image of dut_a (16 words, base 0)
  logic [7:0] mb [64];

  always #5 clk = ~clk;

  dm_bank #(.ADDR_WIDTH(4), .BASE_ADDR(32'h0), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .reset(reset), .pc(pc), .we(a_we), .re(a_re), .op(a_op),
    .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .busy(a_busy),
    .exc_adel(a_adel), .exc_ades(a_ades)
  );

  dm_bank #(.ADDR_WIDTH(4), .BASE_ADDR(32'h1000), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .reset(reset), .pc(pc), .we(b_we), .re(b_re), .op(b_op),
    .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .busy(b_busy),
    .exc_adel(b_adel), .exc_ades(b_ades)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic we, input logic re, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata);
    a_we = we; a_re = re; a_op = op; a_addr = addr; a_wdata = wdata;
    #1;
  endtask

  task automatic drive_b(input logic we, input logic re, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata);
    b_we = we; b_re = re; b_op = op; b_addr = addr; b_wdata = wdata;
    #1;
  endtask

  task automatic zero_model();
    for (int i = 0; i < 64; i++) mb[i] = 8'h00;
  endtask

  // counts edges from reset release until busy drops, bounded
  task automatic sweep_len(output int n);
    n = 0;
    while (a_busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 32'h1000, 0);
    tick(); tick();
    tests++; if (a_busy !== 1'b1) begin fails++; $display("FAIL reset_busy got %b want 1", a_busy); end
    tests++; if (a_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %08h want 0", a_rdata); end
    tests++; if ({a_adel, a_ades} !== 2'b00) begin fails++; $display("FAIL reset_exc got %b want 00", {a_adel, a_ades}); end
    tests++; if (b_busy !== 1'b0) begin fails++; $display("FAIL reset_busy_noclear got %b want 0", b_busy); end
    reset = 1'b0;
    sweep_len(n);
    tests++; if (n !== 16) begin fails++; $display("FAIL sweep_len got %0d want 16", n); end

    // preload word 5, then a one-cycle reset must wipe it
    drive_a(1, 0, 0, 32'h14, 32'hDEADBEEF);
    tick();
    drive_a(0, 1, 0, 32'h14, 0);
    tests++; if (a_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL preload got %08h want deadbeef", a_rdata); end
    drive_a(0, 0, 0, 0, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    sweep_len(n);
    tests++; if (n !== 16) begin fails++; $display("FAIL resweep_len got %0d want 16", n); end
    drive_a(0, 1, 0, 32'h14, 0);
    tests++; if (a_rdata !== 32'h0) begin fails++; $display("FAIL cleared_word got %08h want 0", a_rdata); end

    // reset in the middle of a sweep restarts the full count
    drive_a(0, 0, 0, 0, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    tests++; if (a_busy !== 1'b1) begin fails++; $display("FAIL midsweep_busy got %b want 1", a_busy); end
    reset = 1'b1; tick(); reset = 1'b0;
    sweep_len(n);
    tests++; if (n !== 16) begin fails++; $display("FAIL restart_len got %0d want 16", n); end
  endtask

  task automatic test_busy_gating();
    int n;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    drive_a(1, 0, 0, 32'h0, 32'h12345678);
    tests++; if (a_ades !== 1'b0) begin fails++; $display("FAIL busy_store_exc got %b want 0", a_ades); end
    tests++; if (a_rdata !== 32'h0) begin fails++; $display("FAIL busy_store_rdata got %08h want 0", a_rdata); end
    tick();
    drive_a(1, 1, 0, 32'h2, 32'h1);
    tests++; if ({a_adel, a_ades} !== 2'b00) begin fails++; $display("FAIL busy_bad_exc got %b want 00", {a_adel, a_ades}); end
    drive_a(0, 0, 0, 0, 0);
    sweep_len(n);
    tests++; if (n !== 5) begin fails++; $display("FAIL busy_remaining got %0d want 5", n); end
    drive_a(0, 1, 0, 32'h0, 0);
    tests++; if (a_rdata !== 32'h0) begin fails++; $display("FAIL busy_store_dropped got %08h want 0", a_rdata); end
  endtask

  task automatic test_subword();
    drive_a(1, 0, 0, 32'h0, 32'h11223344); tick();
    drive_a(1, 0, 3, 32'h1, 32'h000000AA); tick();
    drive_a(0, 1, 0, 32'h0, 0);
    tests++; if (a_rdata !== 32'h1122AA44) begin fails++; $display("FAIL sb_merge got %08h want 1122aa44", a_rdata); end
    drive_a(0, 1, 4, 32'h1, 0);
    tests++; if (a_rdata !== 32'hFFFFFFAA) begin fails++; $display("FAIL lb got %08h want ffffffaa", a_rdata); end
    drive_a(0, 1, 3, 32'h1, 0);
    tests++; if (a_rdata !== 32'h000000AA) begin fails++; $display("FAIL lbu got %08h want 000000aa", a_rdata); end
    drive_a(1, 0, 1, 32'h2, 32'hFFFF8001); tick();
    drive_a(0, 1, 2, 32'h2, 0);
    tests++; if (a_rdata !== 32'hFFFF8001) begin fails++; $display("FAIL lh got %08h want ffff8001", a_rdata); end
    drive_a(0, 1, 1, 32'h2, 0);
    tests++; if (a_rdata !== 32'h00008001) begin fails++; $display("FAIL lhu got %08h want 00008001", a_rdata); end
    drive_a(0, 1, 1, 32'h0, 0);
    tests++; if (a_rdata !== 32'h0000AA44) begin fails++; $display("FAIL lhu_low got %08h want 0000aa44", a_rdata); end
  endtask

  task automatic test_misalign();
    drive_a(0, 1, 0, 32'h2, 0);
    tests++; if (a_adel !== 1'b1) begin fails++; $display("FAIL lw_mis_adel got %b want 1", a_adel); end
    tests++; if (a_rdata !== 32'h0) begin fails++; $display("FAIL lw_mis_rdata got %08h want 0", a_rdata); end
    drive_a(1, 0, 1, 32'h3, 32'h0000BEEF);
    tests++; if (a_ades !== 1'b1) begin fails++; $display("FAIL sh_mis_ades got %b want 1", a_ades); end
    tests++; if (a_adel !== 1'b0) begin fails++; $display("FAIL sh_mis_adel got %b want 0", a_adel); end
    tick();
    drive_a(0, 1, 0, 32'h0, 0);
    tests++; if (a_rdata !== 32'h8001AA44) begin fails++; $display("FAIL sh_mis_unchanged got %08h want 8001aa44", a_rdata); end
    drive_a(0, 1, 4, 32'h3, 0);
    tests++; if ({a_adel, a_ades} !== 2'b00) begin fails++; $display("FAIL lb3_exc got %b want 00", {a_adel, a_ades}); end
    tests++; if (a_rdata !== 32'hFFFFFF80) begin fails++; $display("FAIL lb3 got %08h want ffffff80", a_rdata); end
    drive_a(0, 1, 0, 32'h40, 0);
    tests++; if (a_adel !== 1'b1) begin fails++; $display("FAIL a_top_adel got %b want 1", a_adel); end
    drive_a(0, 0, 0, 0, 0);
  endtask

  task automatic test_range_base();
    tests++; if (b_busy !== 1'b0) begin fails++; $display("FAIL b_busy got %b want 0", b_busy); end
    drive_b(1, 0, 0, 32'h103C, 32'h55AA55AA); tick();
    drive_b(1, 0, 0, 32'h0FFC, 32'h0BADBAD0);
    tests++; if (b_ades !== 1'b1) begin fails++; $display("FAIL below_base_ades got %b want 1", b_ades); end
    tick();
    drive_b(1, 0, 0, 32'h1000, 32'hCAFEF00D);
    tests++; if (b_ades !== 1'b0) begin fails++; $display("FAIL base_ades got %b want 0", b_ades); end
    tick();
    drive_b(0, 1, 0, 32'h1000, 0);
    tests++; if (b_rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL base_word got %08h want cafef00d", b_rdata); end
    drive_b(0, 1, 0, 32'h103C, 0);
    tests++; if (b_rdata !== 32'h55AA55AA) begin fails++; $display("FAIL wrap_unchanged got %08h want 55aa55aa", b_rdata); end
    tests++; if (b_adel !== 1'b0) begin fails++; $display("FAIL last_word_adel got %b want 0", b_adel); end
    drive_b(0, 1, 0, 32'h1040, 0);
    tests++; if (b_adel !== 1'b1) begin fails++; $display("FAIL past_end_adel got %b want 1", b_adel); end
    tests++; if (b_rdata !== 32'h0) begin fails++; $display("FAIL past_end_rdata got %08h want 0", b_rdata); end
    drive_b(0, 0, 0, 32'h1000, 0);
  endtask

  task automatic test_back_to_back();
    drive_a(1, 0, 0, 32'h8, 32'hA5A5A5A5); tick();
    drive_a(1, 1, 0, 32'h8, 32'h5A5A5A5A);
    tests++; if (a_rdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL wr_old got %08h want a5a5a5a5", a_rdata); end
    tests++; if ({a_adel, a_ades} !== 2'b00) begin fails++; $display("FAIL wr_exc got %b want 00", {a_adel, a_ades}); end
    tick();
    drive_a(0, 1, 0, 32'h8, 0);
    tests++; if (a_rdata !== 32'h5A5A5A5A) begin fails++; $display("FAIL wr_new got %08h want 5a5a5a5a", a_rdata); end
    drive_a(1, 1, 0, 32'hA, 32'h0);
    tests++; if ({a_adel, a_ades} !== 2'b01) begin fails++; $display("FAIL wr_bad_exc got %b want 01", {a_adel, a_ades}); end
    drive_a(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int n;
    int size;
    logic [31:0] off, exp_rd, ldv;
    logic        bad, sgn;
    logic        we, re;
    logic [2:0]  op;
    logic [31:0] addr, wd;
    reset = 1'b1; tick(); reset = 1'b0;
    sweep_len(n);
    zero_model();
    for (int it = 0; it < 300; it++) begin
      we   = 1'($urandom_range(0, 1));
      re   = 1'($urandom_range(0, 1));
      op   = 3'($urandom_range(0, 7));
      addr = $urandom_range(0, 32'h4F);
      wd   = $urandom;
      pc   = 32'h0040_0000 + 32'(it) * 4;
      size = (op == 3'd1 || op == 3'd2) ? 2 : (op == 3'd3 || op == 3'd4) ? 1 : 4;
      sgn  = (op == 3'd2 || op == 3'd4);
      off  = addr;
      bad  = (off >= 32'd64) || (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
      ldv  = 32'h0;
      if (!bad) begin
        for (int k = 0; k < size; k++) ldv = ldv | (32'(mb[off + 32'(k)]) << (8 * k));
        if (sgn && size == 1 && ldv[7]) ldv = ldv | 32'hFFFF_FF00;
        if (sgn && size == 2 && ldv[15]) ldv = ldv | 32'hFFFF_0000;
      end
      exp_rd = (re && !bad) ? ldv : 32'h0;
      drive_a(we, re, op, addr, wd);
      tests++; if (a_rdata !== exp_rd) begin fails++; $display("FAIL rnd_rdata it=%0d op=%0d addr=%08h got %08h want %08h", it, op, addr, a_rdata, exp_rd); end
      tests++; if (a_ades !== (we && bad)) begin fails++; $display("FAIL rnd_ades it=%0d got %b want %b", it, a_ades, we && bad); end
      tests++; if (a_adel !== (re && !we && bad)) begin fails++; $display("FAIL rnd_adel it=%0d got %b want %b", it, a_adel, re && !we && bad); end
      tick();
      if (we && !bad) begin
        for (int k = 0; k < size; k++) mb[off + 32'(k)] = wd[8*k +: 8];
      end
    end
    drive_a(0, 0, 0, 0, 0);
  endtask

  initial begin
    pc = 32'h0040_0000;
    test_reset();
    test_busy_gating();
    test_subword();
    test_misalign();
    test_range_base();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_bank.md
# dm_bank

Parametrised data memory for the single-cycle/pipelined MIPS datapath, replacing the fixed word-only store. Supports byte/halfword/word loads and stores with sign or zero extension. Detects misaligned and out-of-range accesses. Clears its contents after reset with a one-word-per-cycle sweep instead of a combinational loop. Sits in the MEM stage between the ALU address output and the write-back mux.

## Interface
Parameters:
- ADDR_WIDTH, 12: word-address bits; depth DEPTH = 2^ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- CLEAR_ON_RESET, 1: 1 = zero-sweep after reset; 0 = contents retained, ready immediately.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- pc  in  32  PC of the accessing instruction; used only for the store log line.
- we  in  1  store request.
- re  in  1  load request.
- op  in  3  access type: 000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed; 101–111 treated as word.
- addr  in  32  byte address.
- wdata  in  32  store data; byte uses [7:0], half uses [15:0].
- rdata  out  32  extended load result; combinational.
- busy  out  1  clear sweep in progress.
- exc_adel  out  1  load address error; combinational.
- exc_ades  out  1  store address error; combinational.

## Operation
- Offset: off = addr − BASE_ADDR.
  - Out of range when off ≥ 4·DEPTH, with unsigned compare and wrap on subtraction.
  - Word index = off[ADDR_WIDTH+1:2].
- Misalignment:
  - half access with addr[0]=1.
  - word access with addr[1:0]≠0.
  - byte accesses are never misaligned.
- Errors: bad = misaligned or out of range.
  - exc_ades = we & bad & ~busy.
  - exc_adel = re & ~we & bad & ~busy.
- Loads, when re=1 and not bad:
  - byte: lane addr[1:0], 0 = bits [7:0], 3 = bits [31:24].
  - half: lane addr[1], 0 = bits [15:0].
  - Zero- or sign-extended per op.
  - rdata = 0 when re=0, bad, or busy.
- Stores, when we=1, not bad, and not busy:
  - Only the selected lane(s) of the word are written; other bytes are kept.
  - Same cycle, print: "%d@%08h: *%08h <= %08h" with $time, pc, the word-aligned byte address (addr & ~3), and the full merged word.
  - A store that is bad or issued while busy writes nothing and prints nothing.
- we and re both high: treated as a store; rdata shows pre-write contents and exc_adel = 0.
- FSM has two states, CLEAR and READY.
  - reset=1 → CLEAR with cnt=0 (CLEAR_ON_RESET=1), or READY (CLEAR_ON_RESET=0).
  - In CLEAR, each edge with reset=0 writes mem[cnt]=0 and increments cnt.
  - At cnt=DEPTH−1, that edge writes the last word and moves to READY.
  - READY holds until reset.
  - busy = (state==CLEAR).

## Timing
- Reset values: busy=1 (CLEAR_ON_RESET=1) else 0; rdata=0; exc_adel=exc_ades=0.
- Clear latency: busy stays high for exactly DEPTH edges after the first edge with reset=0.
  - For ADDR_WIDTH=12, that is 4096 cycles.
  - The first access is accepted on the cycle busy reads 0.
- Reset asserted mid-sweep restarts the sweep at cnt=0.
  - Words already cleared stay cleared; the others are cleared again.
- Read latency 0: rdata is valid in the same cycle as addr/op/re.
- A store is committed at the edge. A load of the same word on the next cycle returns the new data.
- Errors are combinational and only flag the current cycle; no sticky state.

## Test plan
- Reset sweep: ADDR_WIDTH=4, preload word 5 = 32'hDEADBEEF, pulse reset 1 cycle.
  - busy is high for 16 cycles; afterwards, lw of 0x14 returns 0.
  - Assert reset at sweep cycle 8: busy lasts 16 cycles from release.
- Sub-word stores/loads: sw 0x0 = 32'h11223344, then sb 0x1 = 8'hAA.
  - lw returns 32'h1122AA44.
  - lb 0x1 returns 32'hFFFFFFAA; lbu returns 32'h000000AA.
  - sh 0x2 = 16'h8001, then lh 0x2 returns 32'hFFFF8001 and lhu returns 32'h00008001.
  - Log shows "*00000000 <= 1122aa44".
- Misalignment: lw 0x2 → exc_adel=1, rdata=0.
  - sh 0x3 → exc_ades=1, memory unchanged, no log line.
  - lb 0x3 → no error.
- Range and base: BASE_ADDR=32'h1000.
  - sw 0x0FFC → exc_ades.
  - sw 0x1000 writes word 0.
  - lw at BASE+4·DEPTH → exc_adel.
- Busy gating: sw during the sweep writes nothing, raises no exception, and prints no log; rdata=0.
- Simultaneous we+re to the same word: rdata shows the old value that cycle and the new value on the next cycle.
